multiply_unit: RTL and testbench

//   16x16 -> 32-bit integer multiplier for the NeoCore execute stage,

---
 rtl/multiply_unit.sv | 19 +
 tb/tb_multiply_unit.sv | 89 ++++++++
 2 files changed

// File: rtl/multiply_unit.sv
// multiply_unit: registered 16x16->32 multiplier, signed (SMULL) or unsigned (UMULL)
module multiply_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  input  logic        is_signed,
  output logic [15:0] result_lo,
  output logic [15:0] result_hi
);
  logic [31:0] w_a, w_b, w_p, r_p;
  // Low 32 bits of a 32x32 product equal the exact 16x16 product once operands are extended per mode
  assign w_a = {{16{is_signed & operand_a[15]}}, operand_a};
  assign w_b = {{16{is_signed & operand_b[15]}}, operand_b};
  assign w_p = w_a * w_b;
  always_ff @(posedge clk) r_p <= rst ? 32'h0 : w_p;
  assign result_lo = r_p[15:0];
  assign result_hi = r_p[31:16];
endmodule

// File: tb/tb_multiply_unit.sv
// tb_multiply_unit: random + directed scoreboard bench for multiply_unit
module tb_multiply_unit;
  logic clk = 1'b0, rst = 1'b1, is_signed = 1'b0;
  logic [15:0] operand_a = '0, operand_b = '0, result_lo, result_hi;
  logic [31:0] exp_q[$];
  logic [31:0] held;
  logic held_valid = 1'b0;
  int checks = 0, errors = 0;

  multiply_unit dut (
    .clk(clk), .rst(rst), .operand_a(operand_a), .operand_b(operand_b),
    .is_signed(is_signed), .result_lo(result_lo), .result_hi(result_hi)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [15:0] a, logic [15:0] b, logic s);
    longint x, y, p;
    x = (s && a[15]) ? longint'(a) - 65536 : longint'(a);
    y = (s && b[15]) ? longint'(b) - 65536 : longint'(b);
    p = x * y;
    return p[31:0];
  endfunction

  task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    rst = r;
    operand_a = a;
    operand_b = b;
    is_signed = s;
    exp_q.push_back(r ? 32'h0 : model(a, b, s));
    #1;
    if (held_valid) begin
      checks++;
      if ({result_hi, result_lo} !== held) begin
        errors++;
        $display("FAIL hold: outputs moved to %h with inputs, required %h", {result_hi, result_lo}, held);
      end
    end
  endtask

  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({result_hi, result_lo} !== e) begin
          errors++;
          $display("FAIL product #%0d: got %h, required %h", checks, {result_hi, result_lo}, e);
        end
        held = e;
        held_valid = 1'b1;
      end
    end
  end

  initial begin
    drive(1'b1, 16'h1234, 16'h5678, 1'b0);
    drive(1'b0, 16'd5, 16'd7, 1'b0);
    drive(1'b0, 16'h0100, 16'h0200, 1'b0);
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    drive(1'b0, 16'hFFFB, 16'd7, 1'b1);
    drive(1'b0, 16'hFF9C, 16'd200, 1'b1);
    drive(1'b0, 16'hFFFB, 16'hFFF9, 1'b1);
    drive(1'b0, 16'h8000, 16'h8000, 1'b1);
    drive(1'b0, 16'h8000, 16'h7FFF, 1'b1);
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    drive(1'b0, 16'h0000, 16'h8000, 1'b1);
    drive(1'b0, 16'hFFFF, 16'h0000, 1'b0);
    drive(1'b0, 16'h7FFF, 16'h7FFF, 1'b1);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    drive(1'b0, 16'd3, 16'd9, 1'b0);
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 15) == 0, 16'($urandom), 16'($urandom), 1'($urandom));
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never appeared, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
